// File: rtl/control_pkg.sv
// control_pkg: shared constants for the hardwired control sequencer.
// Holds the opcode values (IR[31:27]), the 5-bit state encoding, the ALU
// function codes and small opcode-classification helpers.
package control_pkg;

    // Opcode field values
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states; the encoding is what state_out reports
    typedef enum logic [4:0] {
        ST_RESET    = 5'd0,
        ST_T0       = 5'd1,
        ST_T1       = 5'd2,
        ST_T2       = 5'd3,
        ST_T3       = 5'd4,
        ST_T4       = 5'd5,
        ST_T5       = 5'd6,
        ST_T6       = 5'd7,
        ST_T7       = 5'd8,
        ST_HALT     = 5'd9,
        ST_STEPWAIT = 5'd10
    } state_t;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    // Register-register ALU instruction (three-operand form)
    function automatic logic is_alu_rr(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // ALU function for a register-register opcode
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctl_wait_counter.sv
// ctl_wait_counter: 3-bit dwell counter for memory T-states. Cleared while
// not dwelling, so it always starts at zero on entry to a memory state;
// done flags that the state has been held 1+MEM_WAIT cycles.
module ctl_wait_counter #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] wcnt,
    output logic       done
);

    logic [2:0] cnt_r;

    // Count dwell cycles; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (clear) begin
            cnt_r <= 3'd0;
        end else if (enable) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign wcnt = cnt_r;
    assign done = (cnt_r == 3'(MEM_WAIT));

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping the CPU datapath
// through fetch (T0..T2) and execute (T3..T7) states.
// Optional feature macro: CONTROL_SINGLE_STEP_EN adds a step input and a
// STEPWAIT state entered before every fetch.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] ir_op,
    input  logic       con_ff,
`ifdef CONTROL_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       Read,
    output logic       Write,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       Cout,
    output logic       CONin,
    output logic       R15in,
    output logic [3:0] alu_op,
    output logic       run,
    output logic       illegal_op,
    output logic [4:0] state_out
);

`ifdef CONTROL_SINGLE_STEP_EN
    localparam state_t FETCH_ENTRY = ST_STEPWAIT;
`else
    localparam state_t FETCH_ENTRY = ST_T0;
`endif

    state_t     state_r;
    logic [2:0] wcnt_s;
    logic       wait_done_s;
    logic       mem_state_s;
    logic       wait_en_s;

    // Memory states: fetch read, LD data read, ST data write
    always_comb begin
        mem_state_s = 1'b0;
        case (state_r)
            ST_T1:   mem_state_s = 1'b1;
            ST_T6:   mem_state_s = (ir_op == OP_LD);
            ST_T7:   mem_state_s = (ir_op == OP_ST);
            default: mem_state_s = 1'b0;
        endcase
    end

    assign wait_en_s = mem_state_s & ~wait_done_s;

    ctl_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk    (clk),
        .rst_n  (clr),
        .clear  (~wait_en_s),
        .enable (wait_en_s),
        .wcnt   (wcnt_s),
        .done   (wait_done_s)
    );

    // State register and transition logic
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_RESET;
        end else begin
            case (state_r)
                ST_RESET: state_r <= FETCH_ENTRY;
                ST_T0:    state_r <= ST_T1;
                ST_T1:    state_r <= wait_done_s ? ST_T2 : ST_T1;
                ST_T2:    state_r <= ST_T3;
                ST_T3: begin
                    case (ir_op)
                        OP_HALT: state_r <= ST_HALT;
                        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_ADDI, OP_BR, OP_JAL: state_r <= ST_T4;
                        default: state_r <= FETCH_ENTRY;  // JR, NOP, unknown
                    endcase
                end
                ST_T4:    state_r <= (ir_op == OP_JAL) ? FETCH_ENTRY : ST_T5;
                ST_T5: begin
                    case (ir_op)
                        OP_LD, OP_ST, OP_BR: state_r <= ST_T6;
                        default:             state_r <= FETCH_ENTRY;
                    endcase
                end
                ST_T6: begin
                    case (ir_op)
                        OP_LD:   state_r <= wait_done_s ? ST_T7 : ST_T6;
                        OP_ST:   state_r <= ST_T7;
                        default: state_r <= FETCH_ENTRY;
                    endcase
                end
                ST_T7: begin
                    case (ir_op)
                        OP_ST:   state_r <= wait_done_s ? FETCH_ENTRY : ST_T7;
                        default: state_r <= FETCH_ENTRY;
                    endcase
                end
                ST_HALT:  state_r <= ST_HALT;
`ifdef CONTROL_SINGLE_STEP_EN
                ST_STEPWAIT: state_r <= step ? ST_T0 : ST_STEPWAIT;
`endif
                default:  state_r <= ST_RESET;
            endcase
        end
    end

    // Moore strobe decode; ir_op/con_ff only steer T3 and later
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        Read = 1'b0; Write = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; CONin = 1'b0; R15in = 1'b0;
        alu_op = ALU_ADD;
        illegal_op = 1'b0;
        run = (state_r != ST_RESET) && (state_r != ST_HALT);
        case (state_r)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; end
            ST_T1: begin Read = 1'b1; MDRin = 1'b1; IncPC = (wcnt_s == 3'd0); end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_LDI, OP_LD, OP_ST:
                        begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_BR:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL: begin PCout = 1'b1; R15in = 1'b1; end
                    OP_NOP, OP_HALT: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            ST_T4: begin
                if (is_alu_rr(ir_op)) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_code(ir_op);
                end else begin
                    case (ir_op)
                        OP_ADDI, OP_LDI, OP_LD, OP_ST:
                            begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                        OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            ST_T5: begin
                if (is_alu_rr(ir_op) || (ir_op == OP_ADDI) || (ir_op == OP_LDI)) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                    case (ir_op)
                        OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                        OP_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            ST_T6: begin
                case (ir_op)
                    OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR:   begin Zlowout = 1'b1; PCin = con_ff; end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_T7: begin
                case (ir_op)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   Write = 1'b1;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;  // RESET, HALT, STEPWAIT: all strobes low
        endcase
    end

    assign state_out = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int unsigned W = 2;

    localparam logic [20:0] PCOUT  = 21'h100000, PCIN  = 21'h080000, INCPC = 21'h040000;
    localparam logic [20:0] MARIN  = 21'h020000, READ  = 21'h010000, WRITE = 21'h008000;
    localparam logic [20:0] MDRIN  = 21'h004000, MDROUT = 21'h002000, IRIN = 21'h001000;
    localparam logic [20:0] YIN    = 21'h000800, ZIN   = 21'h000400, ZLOW  = 21'h000200;
    localparam logic [20:0] GRA    = 21'h000100, GRB   = 21'h000080, GRC   = 21'h000040;
    localparam logic [20:0] RIN    = 21'h000020, ROUT  = 21'h000010, BAOUT = 21'h000008;
    localparam logic [20:0] COUT   = 21'h000004, CONIN = 21'h000002, R15IN = 21'h000001;
    localparam logic [20:0] NONE   = 21'h000000;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] ir_op;
    logic       con_ff;
`ifdef CONTROL_SINGLE_STEP_EN
    logic       step;
`endif
    logic PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, R15in;
    logic [3:0] alu_op;
    logic run, illegal_op;
    logic [4:0] state_out;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(W)) dut (
        .clk(clk), .clr(clr), .ir_op(ir_op), .con_ff(con_ff),
`ifdef CONTROL_SINGLE_STEP_EN
        .step(step),
`endif
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .CONin(CONin), .R15in(R15in),
        .alu_op(alu_op), .run(run), .illegal_op(illegal_op), .state_out(state_out)
    );

    typedef struct packed {
        logic [4:0]  st;
        logic [20:0] strb;
        logic [3:0]  alu;
        logic        rn;
        logic        ill;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    logic [20:0] strb_s;
    assign strb_s = {PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin, Yin,
                     Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, R15in};

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string nm;
        a = {state_out, strb_s, alu_op, run, illegal_op};
        n_checks++;
        if ($countones({PCout, Rout, MDRout, Zlowout, Cout, BAout}) > 1) begin
            n_fail++;
            $display("FAIL bus_exclusive: got drivers=%b, want at most one set",
                     {PCout, Rout, MDRout, Zlowout, Cout, BAout});
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d strb=%h alu=%0d run=%b ill=%b, want st=%0d strb=%h alu=%0d run=%b ill=%b",
                         nm, a.st, a.strb, a.alu, a.rn, a.ill, e.st, e.strb, e.alu, e.rn, e.ill);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [4:0] st, input logic [20:0] strb,
                            input logic [3:0] alu, input logic rn, input logic ill);
        obs_t e;
        e = {st, strb, alu, rn, ill};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Queue one cycle of expected output, then move to just after the next edge
    task automatic chk(input string nm, input logic [4:0] st, input logic [20:0] strb,
                       input logic [3:0] alu, input logic rn, input logic ill);
        push_exp(nm, st, strb, alu, rn, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
`ifdef CONTROL_SINGLE_STEP_EN
        chk({nm, "_stepwait"}, ST_STEPWAIT, NONE, 4'd0, 1'b1, 1'b0);
`endif
        chk({nm, "_t0"}, ST_T0, PCOUT | MARIN, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i <= int'(W); i++)
            chk({nm, "_t1"}, ST_T1, READ | MDRIN | ((i == 0) ? INCPC : NONE), 4'd0, 1'b1, 1'b0);
        chk({nm, "_t2"}, ST_T2, MDROUT | IRIN, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic mem_state(input string nm, input logic [4:0] st, input logic [20:0] strb);
        for (int i = 0; i <= int'(W); i++)
            chk(nm, st, strb, 4'd0, 1'b1, 1'b0);
    endtask

    // Address phase shared by LD and ST
    task automatic ldst_addr(input string nm);
        chk({nm, "_t3"}, ST_T3, GRB | BAOUT | YIN, 4'd0, 1'b1, 1'b0);
        chk({nm, "_t4"}, ST_T4, COUT | ZIN, 4'd0, 1'b1, 1'b0);
        chk({nm, "_t5"}, ST_T5, ZLOW | MARIN, 4'd0, 1'b1, 1'b0);
    endtask

    logic [4:0] rr_op  [4] = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    logic [3:0] rr_alu [4] = '{4'd0, 4'd1, 4'd2, 4'd3};

    initial begin
        clr = 1'b0; ir_op = OP_NOP; con_ff = 1'b0;
`ifdef CONTROL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        @(posedge clk); #1;
        chk("reset_0", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        chk("reset_1", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        clr = 1'b1;
        chk("reset_rel", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);

        ir_op = OP_NOP; fetch("nop");
        chk("nop_t3", ST_T3, NONE, 4'd0, 1'b1, 1'b0);

        ir_op = OP_JAL; fetch("jal");
        chk("jal_t3", ST_T3, PCOUT | R15IN, 4'd0, 1'b1, 1'b0);
        chk("jal_t4", ST_T4, GRA | ROUT | PCIN, 4'd0, 1'b1, 1'b0);

        for (int c = 0; c < 2; c++) begin
            ir_op = OP_BR; con_ff = c[0]; fetch("br");
            chk("br_t3", ST_T3, GRA | ROUT | CONIN, 4'd0, 1'b1, 1'b0);
            chk("br_t4", ST_T4, PCOUT | YIN, 4'd0, 1'b1, 1'b0);
            chk("br_t5", ST_T5, COUT | ZIN, 4'd0, 1'b1, 1'b0);
            chk("br_t6", ST_T6, ZLOW | ((c == 1) ? PCIN : NONE), 4'd0, 1'b1, 1'b0);
        end
        con_ff = 1'b0;

        for (int k = 0; k < 4; k++) begin
            ir_op = rr_op[k]; fetch("alu");
            chk("alu_t3", ST_T3, GRB | ROUT | YIN, 4'd0, 1'b1, 1'b0);
            chk("alu_t4", ST_T4, GRC | ROUT | ZIN, rr_alu[k], 1'b1, 1'b0);
            chk("alu_t5", ST_T5, ZLOW | GRA | RIN, 4'd0, 1'b1, 1'b0);
        end

        ir_op = OP_ADDI; fetch("addi");
        chk("addi_t3", ST_T3, GRB | ROUT | YIN, 4'd0, 1'b1, 1'b0);
        chk("addi_t4", ST_T4, COUT | ZIN, 4'd0, 1'b1, 1'b0);
        chk("addi_t5", ST_T5, ZLOW | GRA | RIN, 4'd0, 1'b1, 1'b0);

        ir_op = OP_LDI; fetch("ldi");
        chk("ldi_t3", ST_T3, GRB | BAOUT | YIN, 4'd0, 1'b1, 1'b0);
        chk("ldi_t4", ST_T4, COUT | ZIN, 4'd0, 1'b1, 1'b0);
        chk("ldi_t5", ST_T5, ZLOW | GRA | RIN, 4'd0, 1'b1, 1'b0);

        ir_op = OP_LD; fetch("ld");
        ldst_addr("ld");
        mem_state("ld_t6", ST_T6, READ | MDRIN);
        chk("ld_t7", ST_T7, MDROUT | GRA | RIN, 4'd0, 1'b1, 1'b0);

        ir_op = OP_ST; fetch("st");
        ldst_addr("st");
        chk("st_t6", ST_T6, GRA | ROUT | MDRIN, 4'd0, 1'b1, 1'b0);
        mem_state("st_t7", ST_T7, WRITE);

        ir_op = OP_JR; fetch("jr");
        chk("jr_t3", ST_T3, GRA | ROUT | PCIN, 4'd0, 1'b1, 1'b0);

        ir_op = 5'b11111; fetch("ill");
        chk("ill_t3", ST_T3, NONE, 4'd0, 1'b1, 1'b1);

        ir_op = OP_HALT; fetch("halt");
        chk("halt_t3", ST_T3, NONE, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            chk("halt_hold", ST_HALT, NONE, 4'd0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("halt_clr", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        clr = 1'b1;
        chk("halt_rel", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        ir_op = OP_NOP; fetch("restart");
        chk("restart_t3", ST_T3, NONE, 4'd0, 1'b1, 1'b0);

        // Reset in the middle of ST, during T6
        ir_op = OP_ST; fetch("stabort");
        ldst_addr("stabort");
        push_exp("stabort_t6", ST_T6, GRA | ROUT | MDRIN, 4'd0, 1'b1, 1'b0);
        @(negedge clk); #1;
        clr = 1'b0;
        #1;
        n_checks++;
        if ({state_out, strb_s, alu_op, run, illegal_op} !== {ST_RESET, NONE, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stabort_async: got st=%0d strb=%h alu=%0d run=%b, want st=%0d strb=0 alu=0 run=0",
                     state_out, strb_s, alu_op, run, ST_RESET);
        end
        @(posedge clk); #1;
        chk("stabort_rst0", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        chk("stabort_rst1", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        clr = 1'b1;
        chk("stabort_rel", ST_RESET, NONE, 4'd0, 1'b0, 1'b0);
        ir_op = OP_NOP; fetch("after_abort");
        chk("after_abort_t3", ST_T3, NONE, 4'd0, 1'b1, 1'b0);

        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the existing CPU datapath through fetch and execute T-states.
- Replaces per-instruction testbench FSMs with a single synthesizable Moore FSM.
- Input is the registered opcode field IR[31:27] and the CON flip-flop. Outputs are the datapath strobes (PCout, MARin, IncPC, Read, MDRin, Gra, Rout, R15in, etc.) plus an ALU operation code.
- Sits beside the Datapath in the CPU top level.

Parameters:
- MEM_WAIT, 0, extra cycles Read/MDRin or Write are held for a memory access (0..7).

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- ir_op  in  5  opcode IR[31:27]; valid from T3 onward
- con_ff  in  1  branch condition from CON logic
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes
- Read, Write, MDRin, MDRout  out  1 each  memory/MDR strobes
- IRin, Yin, Zin, Zlowout  out  1 each  IR/ALU register strobes
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and bus strobes
- CONin, R15in  out  1 each  CON load, link-register load
- alu_op  out  4  ALU function, meaningful only while Zin=1
- run  out  1  1 while executing, 0 in RESET/HALT
- illegal_op  out  1  one-cycle pulse in T3 for an unknown opcode
- state_out  out  5  current state encoding, for monitoring

Behaviour:
- Clock and reset: one clock domain. clr=0 asynchronously forces state RESET; all outputs 0, run=0, alu_op=0.
- Reset release: first rising edge goes RESET->T0. run=1 from T0.
- Output timing: Moore outputs, decoded from registered state only; no combinational path from ir_op to outputs except in T3 and later.
- State advance: one clock per state. Exception: memory states stay 1+MEM_WAIT cycles, counted by wait counter wcnt.
- Fetch:
  - T0: PCout, MARin.
  - T1 (memory state): Read, MDRin held all cycles; IncPC only in the first cycle.
  - T2: MDRout, IRin.
- ADD 00011 / SUB 00100 / AND 00101 / OR 00110:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op = op.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- ADDI 01100, LDI 00001:
  - T3: Grb, Rout, Yin. ADDI uses Rout; LDI uses BAout instead of Rout.
  - T4: Cout, Zin, alu_op=ADD.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- LD 00000:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ADD.
  - T5: Zlowout, MARin.
  - T6 (memory state): Read, MDRin.
  - T7: MDRout, Gra, Rin.
- ST 00010:
  - T3–T5 as LD.
  - T6: Gra, Rout, MDRin.
  - T7 (memory state): Write.
- BR 10010:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, ADD.
  - T6: Zlowout; PCin only if con_ff=1 (sampled in T6).
- JR 10100: T3: Gra, Rout, PCin.
- JAL 10011:
  - T3: PCout, R15in.
  - T4: Gra, Rout, PCin.
- NOP 11010: T3 then T0.
- HALT 11011: T3 -> HALT. In HALT all strobes are 0 and run=0; HALT exits only via clr.
- Unknown opcode: illegal_op=1 in T3, then T0; treated as NOP.
- Instruction end: after the last T-state of each instruction, next state is T0.
- Exclusivity: at most one bus driver (PCout, Rout, MDRout, Zlowout, Cout, BAout) is asserted per cycle.
- alu_op codes: ADD=0, SUB=1, AND=2, OR=3.
- Wait counter: wcnt is 3-bit, cleared on entry to each memory state; that state exits when wcnt==MEM_WAIT.
- Reset mid-instruction: immediate return to RESET; the partial instruction is abandoned with no further strobes.

Optional Feature:
- Macro: CONTROL_SINGLE_STEP_EN.
- Enabled: adds input step (1 bit) and a state STEPWAIT, entered in place of T0 after every completed instruction. STEPWAIT holds with all strobes 0 and run=1 until a sampled step=1, then goes to T0. The first fetch after reset also waits in STEPWAIT.
- Disabled: no step port, no STEPWAIT; instructions run back-to-back.

Decomposition:
- Package control_pkg:
  - opcode localparams (LD..HALT);
  - state encoding (RESET, T0..T7, HALT, STEPWAIT; 5-bit);
  - alu_op codes.
- Sub-module ctl_wait_counter: 3-bit counter with clear and done-compare against MEM_WAIT. Shared by the T1, T6 and T7 memory states.

Test Plan:
- Fetch after reset, MEM_WAIT=0: clr low, then high; ir_op=NOP -> T0 (PCout=MARin=1) in cycle 1, T1 (Read=MDRin=IncPC=1) in cycle 2, T2 (MDRout=IRin=1) in cycle 3, T3, then T0 in cycle 5.
- JAL: ir_op=10011 -> T3 has PCout=R15in=1 and no other strobes; T4 has Gra=Rout=PCin=1; T0 on the next edge.
- BR: ir_op=10010 -> T6 asserts Zlowout with PCin=0 when con_ff=0, and PCin=1 when con_ff=1. Both cases return to T0.
- LD, MEM_WAIT=2: T1 holds Read=MDRin=1 for 3 cycles with IncPC high only in the first; T6 holds Read=MDRin=1 for 3 cycles. T7 gives MDRout=Gra=Rin=1.
- HALT and illegal opcode:
  - ir_op=11011 -> run falls after T3; all strobes stay 0 for 20 cycles; a clr pulse restarts at T0.
  - ir_op=11111 -> illegal_op pulses one cycle, then T0.
- Reset mid-ST: assert clr in T6 -> all outputs 0 before the next clock edge, state_out=RESET, and Write is never asserted.
